// File: rtl/puf_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | puf_pkg : shared states, default constants and LFSR step for the PUF       |
// |           race sequencer.                                                 |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package puf_pkg;

  localparam int unsigned PUF_CHAL_W     = 32;
  localparam logic [31:0] PUF_LFSR_TAPS  = 32'h8020_0003;
  localparam int unsigned PUF_LFSR_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } puf_state_e;

  // Right-shifting Galois step; callers zero-extend state and mask to 64 bits.
  function automatic logic [PUF_LFSR_MAX_W-1:0] lfsr_next(
    input logic [PUF_LFSR_MAX_W-1:0] s,
    input logic [PUF_LFSR_MAX_W-1:0] taps
  );
    lfsr_next = (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_race_sequencer_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | puf_race_sequencer_if : host request/response and race datapath signals.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface puf_race_sequencer_if
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W = PUF_CHAL_W,
  parameter int unsigned RESP_W = 8
);
  logic              start;
  logic [CHAL_W-1:0] challenge_in;
  logic              busy;
  logic              resp_valid;
  logic [RESP_W-1:0] response;
  logic              timeout_err;
  logic [CHAL_W-1:0] race_chal;
  logic              race_reset;
  logic              race_go;
  logic              race_done;
  logic              race_out;

  // master: host plus race arbiter side; slave: the sequencer.
  modport master (
    output start, challenge_in, race_done, race_out,
    input  busy, resp_valid, response, timeout_err, race_chal, race_reset, race_go
  );

  modport slave (
    input  start, challenge_in, race_done, race_out,
    output busy, resp_valid, response, timeout_err, race_chal, race_reset, race_go
  );
endinterface
`default_nettype wire

// File: rtl/puf_sync2.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | puf_sync2 : two-flop synchronizer for one asynchronous level.             |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module puf_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];
endmodule
`default_nettype wire

// File: rtl/puf_race_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | puf_race_sequencer : arbiter-PUF challenge/response controller. Define    |
// | PUF_MAJ_VOTE_EN to majority-vote VOTES evaluations per response bit.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module puf_race_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned       CHAL_W      = PUF_CHAL_W,
  parameter int unsigned       RESP_W      = 8,
  parameter logic [CHAL_W-1:0] LFSR_TAPS   = CHAL_W'(PUF_LFSR_TAPS),
  parameter int unsigned       SETTLE_CYC  = 4,
  parameter int unsigned       TIMEOUT_CYC = 1024,
  parameter int unsigned       VOTES       = 3
) (
  input logic                  clk,
  input logic                  reset,
  puf_race_sequencer_if.slave  bus
);

  localparam int unsigned IDX_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYC);
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_W - 1);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT_CYC - 1);

  if (RESP_W == 0) begin : g_chk_resp_w
    $error("RESP_W must be at least 1");
  end
  if (SETTLE_CYC < 3) begin : g_chk_settle
    $error("SETTLE_CYC must be at least 3 so the synchronizers flush during ARM");
  end
  if ((VOTES % 2) == 0) begin : g_chk_votes
    $error("VOTES must be odd");
  end

  puf_state_e        state_q;
  logic [CHAL_W-1:0] lfsr_q;
  logic [CHAL_W-1:0] lfsr_d;
  logic [CHAL_W-1:0] race_chal_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SET_W-1:0]  settle_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [RESP_W-1:0] response_q;
  logic              busy_q;
  logic              resp_valid_q;
  logic              timeout_err_q;
  logic              race_reset_q;
  logic              race_go_q;

  logic              done_sync;
  logic              out_sync;
  logic [CHAL_W-1:0] seed;
  logic              race_bit;
  logic              tmo_hit;
  logic              run_end;
  logic              last_vote;
  logic              bit_val;

  puf_sync2 u_sync_done (.clk(clk), .reset(reset), .d_i(bus.race_done), .q_o(done_sync));
  puf_sync2 u_sync_out  (.clk(clk), .reset(reset), .d_i(bus.race_out),  .q_o(out_sync));

  // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
  assign seed     = (bus.challenge_in == '0) ? '1 : bus.challenge_in;
  assign lfsr_d   = CHAL_W'(lfsr_next(PUF_LFSR_MAX_W'(lfsr_q), PUF_LFSR_MAX_W'(LFSR_TAPS)));
  assign race_bit = done_sync & out_sync;
  assign tmo_hit  = (tmo_q == LAST_TMO);
  assign run_end  = done_sync | tmo_hit;

`ifdef PUF_MAJ_VOTE_EN
  localparam int unsigned VOTE_W = $clog2(VOTES + 1);

  logic [VOTE_W-1:0] vote_q;
  logic [VOTE_W-1:0] ones_q;
  logic [VOTE_W-1:0] ones_d;

  assign ones_d    = ones_q + VOTE_W'(race_bit);
  assign last_vote = (vote_q == VOTE_W'(VOTES - 1));
  assign bit_val   = (ones_d > VOTE_W'(VOTES / 2));
`else
  assign last_vote = 1'b1;
  assign bit_val   = race_bit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      lfsr_q        <= '0;
      race_chal_q   <= '0;
      idx_q         <= '0;
      settle_q      <= '0;
      tmo_q         <= '0;
      response_q    <= '0;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      race_reset_q  <= 1'b1;
      race_go_q     <= 1'b0;
`ifdef PUF_MAJ_VOTE_EN
      vote_q        <= '0;
      ones_q        <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          race_reset_q <= 1'b1;
          race_go_q    <= 1'b0;
          if (bus.start) begin
            lfsr_q        <= seed;
            race_chal_q   <= seed;
            idx_q         <= '0;
            settle_q      <= '0;
            response_q    <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ARM;
`ifdef PUF_MAJ_VOTE_EN
            vote_q        <= '0;
            ones_q        <= '0;
`endif
          end
        end

        ARM: begin
          if (settle_q == LAST_SET) begin
            settle_q     <= '0;
            tmo_q        <= '0;
            race_reset_q <= 1'b0;
            race_go_q    <= 1'b1;
            state_q      <= RUN;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        RUN: begin
          // A done seen on the final timeout cycle still counts as a result.
          if (run_end) begin
            race_reset_q <= 1'b1;
            race_go_q    <= 1'b0;
            if (!done_sync) begin
              timeout_err_q <= 1'b1;
            end
            if (last_vote) begin
              response_q <= response_q | (RESP_W'(bit_val) << idx_q);
              state_q    <= STEP;
            end else begin
              state_q    <= ARM;
            end
`ifdef PUF_MAJ_VOTE_EN
            vote_q <= last_vote ? '0 : vote_q + 1'b1;
            ones_q <= last_vote ? '0 : ones_d;
`endif
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        STEP: begin
          lfsr_q      <= lfsr_d;
          race_chal_q <= lfsr_d;
          if (idx_q == LAST_IDX) begin
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ARM;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.response    = response_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.race_chal   = race_chal_q;
  assign bus.race_reset  = race_reset_q;
  assign bus.race_go     = race_go_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_race_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_puf_race_sequencer : self-checking bench with a behavioural race model. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_puf_race_sequencer;

  localparam int unsigned CHAL_W = 32;
  localparam int unsigned RESP_W = 8;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 1024;
  localparam logic [31:0] TAPS   = 32'h8020_0003;
`ifdef PUF_MAJ_VOTE_EN
  localparam int VPB = 3;
`else
  localparam int VPB = 1;
`endif
  localparam int MAXR   = RESP_W * VPB;
  localparam int BUDGET = 40000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  puf_race_sequencer_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus ();

  puf_race_sequencer #(
    .CHAL_W(CHAL_W), .RESP_W(RESP_W), .LFSR_TAPS(TAPS),
    .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .VOTES(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Race plan per evaluation: winner bit and done delay in RUN cycles (0 = never).
  bit          win_tab[MAXR];
  int          dly_tab[MAXR];
  logic [31:0] chal_exp[RESP_W];
  int          race_n = 0;
  int          race_base = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'd0);
  endfunction

  // Race arbiter model: done rises on the n-th RUN cycle, winner appears with it.
  initial begin
    int go_cnt;
    int cur;
    go_cnt = 0;
    cur = 0;
    bus.race_done = 1'b0;
    bus.race_out  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.race_reset) begin
        bus.race_done = 1'b0;
        bus.race_out  = 1'($urandom_range(0, 1));
        go_cnt = 0;
      end else if (bus.race_go) begin
        go_cnt++;
        if (go_cnt == 1) begin
          cur = race_n - race_base;
          race_n++;
          if (cur < MAXR) check("race_chal", 64'(bus.race_chal), 64'(chal_exp[cur / VPB]));
        end
        if (!bus.race_done) bus.race_out = 1'($urandom_range(0, 1));
        if (cur < MAXR && dly_tab[cur] != 0 && go_cnt == dly_tab[cur]) begin
          bus.race_done = 1'b1;
          bus.race_out  = win_tab[cur];
        end
      end
      check("reset_vs_go", 64'(bus.race_reset), 64'(!bus.race_go));
    end
  end

  task automatic set_kind(input int kind);
    for (int b = 0; b < RESP_W; b++) begin
      for (int v = 0; v < VPB; v++) begin
        int r;
        r = b * VPB + v;
        dly_tab[r] = 10;
        case (kind)
          0: win_tab[r] = 1'b1;
          1: win_tab[r] = (b % 2 == 0);
          2: begin win_tab[r] = 1'b1; if (b == 3) dly_tab[r] = 0; end
          3: win_tab[r] = (v != 1);
          default: win_tab[r] = (v == 2);
        endcase
      end
    end
  endtask

  task automatic run_txn(input string tag, input logic [31:0] chal, input bit extra,
                         input bit use_exp, input logic [7:0] t_resp, input bit t_tmo);
    logic [7:0]  m_resp;
    bit          m_tmo;
    int          m_cyc;
    int          k;
    int          n_valid;
    logic [31:0] s;
    m_resp = '0;
    m_tmo  = 1'b0;
    m_cyc  = 0;
    for (int b = 0; b < RESP_W; b++) begin
      int ones;
      ones = 0;
      for (int v = 0; v < VPB; v++) begin
        int r;
        r = b * VPB + v;
        if (dly_tab[r] == 0 || dly_tab[r] + 2 > TMO) begin
          m_tmo = 1'b1;
          m_cyc += SETTLE + TMO;
        end else begin
          ones += int'(win_tab[r]);
          m_cyc += SETTLE + dly_tab[r] + 2;
        end
      end
      m_resp[b] = (ones * 2 > VPB);
    end
    m_cyc += RESP_W + 1;
    if (use_exp) begin
      m_resp = t_resp;
      m_tmo  = t_tmo;
    end
    s = (chal == 32'd0) ? 32'hFFFF_FFFF : chal;
    for (int b = 0; b < RESP_W; b++) begin
      chal_exp[b] = s;
      s = lfsr_step(s);
    end
    race_base = race_n;

    @(negedge clk);
    bus.start = 1'b1;
    bus.challenge_in = chal;
    @(negedge clk);
    bus.start = 1'b0;
    bus.challenge_in = $urandom;
    check({tag, " busy_c1"}, 64'(bus.busy), 64'd1);
    check({tag, " tmo_cleared"}, 64'(bus.timeout_err), 64'd0);
    check({tag, " chal_c1"}, 64'(bus.race_chal), 64'(chal_exp[0]));
    k = 1;
    while (!bus.resp_valid && k < BUDGET) begin
      bus.start = (extra && k == 20);
      if (extra && k == 20) bus.challenge_in = ~chal;
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check({tag, " resp_valid_seen"}, 64'(bus.resp_valid), 64'd1);
    check({tag, " latency"}, 64'(k), 64'(m_cyc));
    check({tag, " response"}, 64'(bus.response), 64'(m_resp));
    check({tag, " timeout_err"}, 64'(bus.timeout_err), 64'(m_tmo));
    check({tag, " busy_at_valid"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    check({tag, " busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, " resp_hold"}, 64'(bus.response), 64'(m_resp));
    n_valid = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.resp_valid) n_valid++;
    end
    check({tag, " extra_valid"}, 64'(n_valid), 64'd0);
    check({tag, " idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  typedef struct packed {
    logic [31:0] chal;
    logic [2:0]  kind;
    logic        extra;
    logic [7:0]  exp_resp;
    logic        exp_tmo;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bus.start = 1'b0;
    bus.challenge_in = '0;
    vecs[0] = '{32'h0000_0001, 3'd0, 1'b0, 8'hFF, 1'b0};
    vecs[1] = '{32'h0000_0001, 3'd1, 1'b0, 8'h55, 1'b0};
    vecs[2] = '{32'hA5A5_0F0F, 3'd2, 1'b0, 8'hF7, 1'b1};
    vecs[3] = '{32'h1234_5678, 3'd0, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{32'h0000_0000, 3'd0, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{32'hDEAD_BEEF, 3'd3, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{32'hCAFE_F00D, 3'd4, 1'b0, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst response", 64'(bus.response), 64'd0);
    check("rst timeout_err", 64'(bus.timeout_err), 64'd0);
    check("rst race_reset", 64'(bus.race_reset), 64'd1);
    check("rst race_go", 64'(bus.race_go), 64'd0);
    check("rst race_chal", 64'(bus.race_chal), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      set_kind(int'(vecs[i].kind));
      run_txn($sformatf("vec%0d", i), vecs[i].chal, vecs[i].extra, 1'b1,
              vecs[i].exp_resp, vecs[i].exp_tmo);
    end

    // Reset during the RUN phase of bit 5 discards the request.
    begin
      int w;
      int n_valid;
      set_kind(0);
      race_base = race_n;
      for (int b = 0; b < RESP_W; b++) chal_exp[b] = 32'd0;
      chal_exp[0] = 32'h0000_00A5;
      for (int b = 1; b < RESP_W; b++) chal_exp[b] = lfsr_step(chal_exp[b-1]);
      @(negedge clk);
      bus.start = 1'b1;
      bus.challenge_in = 32'h0000_00A5;
      @(negedge clk);
      bus.start = 1'b0;
      w = 0;
      while ((race_n - race_base) <= 5 * VPB && w < BUDGET) begin
        @(negedge clk);
        w++;
      end
      check("rst_mid reached_bit5", 64'((race_n - race_base) > 5 * VPB), 64'd1);
      repeat (3) @(negedge clk);
      check("rst_mid in_run", 64'(bus.race_go), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid race_reset", 64'(bus.race_reset), 64'd1);
      check("rst_mid race_go", 64'(bus.race_go), 64'd0);
      check("rst_mid busy", 64'(bus.busy), 64'd0);
      check("rst_mid response", 64'(bus.response), 64'd0);
      reset = 1'b0;
      n_valid = 0;
      repeat (300) begin
        @(negedge clk);
        if (bus.resp_valid) n_valid++;
      end
      check("rst_mid no_valid", 64'(n_valid), 64'd0);
      check("rst_mid idle", 64'(bus.busy), 64'd0);
      set_kind(0);
      run_txn("after_rst", 32'h0BAD_CAFE, 1'b0, 1'b1, 8'hFF, 1'b0);
    end

    // Randomized requests against the behavioural model.
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < MAXR; r++) begin
        win_tab[r] = 1'($urandom_range(0, 1));
        dly_tab[r] = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 20));
      end
      run_txn($sformatf("rnd%0d", t), $urandom, 1'b0, 1'b0, 8'h00, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/puf_race_sequencer.md
Name: puf_race_sequencer

Overview:
- Challenge/response controller for the arbiter-PUF race datapath: drives race challenge, race reset and launch, waits for the race-done flag, and captures the winner bit.
- Derives RESP_W sub-challenges from one input challenge with an internal LFSR and assembles a RESP_W-bit response.
- Sits between the host/bus register block and the race arbiter plus counter pair.
- Owns race timing, timeout and clock-domain crossing of the race outputs.

Parameters:
- CHAL_W, 32, challenge width and LFSR width.
- RESP_W, 8, response bits per request; must be ≥ 1.
- LFSR_TAPS, 32'h80200003, Galois feedback mask.
- SETTLE_CYC, 4, cycles race_reset is held per evaluation; must be ≥ 3.
- TIMEOUT_CYC, 1024, maximum RUN cycles per evaluation.
- VOTES, 3, evaluations per bit when MAJ_VOTE_EN is defined; must be odd.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse; sampled in IDLE only.
- challenge_in  in  CHAL_W  seed challenge; latched on an accepted start.
- busy  out  1  high from the cycle after start acceptance until DONE exits.
- resp_valid  out  1  one-cycle pulse; response is valid on this cycle.
- response  out  CHAL_W→RESP_W  assembled response (RESP_W bits), LSB = first evaluation; holds until next accepted start.
- timeout_err  out  1  sticky; set if any evaluation timed out; cleared on accepted start.
- race_chal  out  CHAL_W  current sub-challenge to the delay lines.
- race_reset  out  1  resets race counters/arbiter.
- race_go  out  1  launches the race.
- race_done  in  1  asynchronous race-finished flag.
- race_out  in  1  asynchronous winner bit; unknown while race_reset is high.

Behaviour:
- Reset values: busy=0, resp_valid=0, response=0, timeout_err=0, race_reset=1, race_go=0, race_chal=0, state=IDLE, LFSR=0, counters=0.
- CDC: race_done and race_out each pass through a 2-flop synchronizer. Only the synchronized versions are used. race_out is sampled on the first cycle synced race_done is high.
- IDLE: race_reset=1, race_go=0.
  - start=1 → latch challenge_in into the LFSR. A zero seed is replaced by all-ones.
  - Clear bit index, response, and timeout_err; go to ARM.
- ARM: race_reset=1, race_go=0, race_chal=LFSR. Lasts exactly SETTLE_CYC cycles, then RUN.
- RUN: race_reset=0, race_go=1, timeout counter increments each cycle.
  - First cycle synced race_done=1 → response[idx] = synced race_out; go to STEP.
  - Counter reaches TIMEOUT_CYC with no done → response[idx]=0, timeout_err=1; go to STEP.
  - If done and timeout occur in the same cycle, done wins.
- STEP (1 cycle): race_go=0, race_reset=1, LFSR advances one step.
  - If idx == RESP_W-1 → DONE; else idx++ and go to ARM.
- DONE (1 cycle): resp_valid=1, then IDLE. busy drops the cycle after DONE.
- Latency per bit: SETTLE_CYC + (2 sync + race duration) + 1.
- start while busy is ignored; no queueing.
- reset mid-operation: returns to IDLE next edge. race_reset goes to 1 immediately, the partial response is discarded, and no resp_valid is generated.
- race_done already high when entering RUN (stuck-high arbiter) is accepted as a result. The SETTLE_CYC ≥ 3 rule guarantees the synchronizer has flushed first.

Optional Feature:
- Macro: PUF_MAJ_VOTE_EN.
- Defined: each response bit runs the ARM/RUN sequence VOTES times on the same sub-challenge.
  - Winner bits are counted; the bit is 1 iff count > VOTES/2.
  - A timed-out vote counts as 0 and still sets timeout_err.
  - The LFSR advances only after the final vote.
- Undefined: one evaluation per bit; the VOTES parameter is unused and no vote counter is present.

Decomposition:
- Shared package puf_pkg holds:
  - state enum (IDLE, ARM, RUN, STEP, DONE);
  - default CHAL_W/LFSR_TAPS constants;
  - the LFSR next-state function.
- Natural sub-module: puf_sync2, the 2-flop synchronizer, instantiated twice.
- LFSR and counters stay inline.

Test Plan:
- Race model returns done after 10 cycles with out=1 every race; start with challenge 32'h0000_0001 → resp_valid after 8×(4+12+1)+1 cycles, response=8'hFF, timeout_err=0.
- Model alternates winners 1,0,1,0… → response=8'h55. race_chal sequence matches the golden LFSR from seed 1; race_reset is high in every ARM/STEP cycle.
- Model never asserts done on bit 3 → bit 3=0 after 1024 RUN cycles; timeout_err=1 at resp_valid; next start clears it.
- challenge_in=0 → first race_chal=32'hFFFF_FFFF. A second start pulse while busy is ignored: exactly one resp_valid.
- reset asserted during RUN of bit 5 → next cycle race_reset=1, race_go=0, busy=0; no resp_valid; a new start completes normally.
- With PUF_MAJ_VOTE_EN, VOTES=3, votes 1,0,1 per bit → bit=1. Votes 0,0,1 → bit=0; race_chal is unchanged across the votes of one bit.
